// File: rtl/iq_mixer.sv
// ---------------------------------------------------------------------------
// iq_mixer -- quadrature downconverter with built-in NCO.
//
// Multiplies the incoming sample by e^(-j*phase) where phase comes from a
// 32-bit (AW) accumulator stepped once per accepted sample. The result is
// rounded half-up and saturated to OW bits per rail. Latency is three
// clock-enabled edges: S1 table lookup, S2 products, S3 combine/round/sat.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_ce                clock enable, low freezes every pipeline register
//   i_valid             sample valid (accepted when i_ce & i_valid)
//   i_mode              0 = real input (i_data_i only), 1 = complex input
//   i_data_i/i_data_q   signed input samples, IW bits
//   i_update            loads i_increment into the increment register
//   i_increment         phase step per accepted sample, AW bits
//   i_phase_offset      static phase offset added at the top PW bits
//   o_valid             output valid (S3)
//   o_signal_i/_q       mixed I / Q, signed OW bits, hold during bubbles
//
// Build option: define IQ_MIXER_DITHER_EN to add a 15-bit LFSR phase dither
// below the table index, spreading truncation spurs.
// ---------------------------------------------------------------------------
module iq_mixer #(
  parameter int IW = 16,
  parameter int OW = 16,
  parameter int LW = 16,
  parameter int PW = 12,
  parameter int AW = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ce,
  input  logic                 i_valid,
  input  logic                 i_mode,
  input  logic signed [IW-1:0] i_data_i,
  input  logic signed [IW-1:0] i_data_q,
  input  logic                 i_update,
  input  logic        [AW-1:0] i_increment,
  input  logic        [PW-1:0] i_phase_offset,
  output logic                 o_valid,
  output logic signed [OW-1:0] o_signal_i,
  output logic signed [OW-1:0] o_signal_q
);

  localparam int PRW = IW + LW;      // product width
  localparam int SW  = IW + LW + 1;  // combined sum width
  localparam int N4  = 2 ** (PW - 2); // entries per quarter turn

  localparam logic signed [SW-1:0] RND  = {{(SW-LW+1){1'b0}}, 1'b1, {(LW-2){1'b0}}};
  localparam logic signed [SW-1:0] OMAX = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [SW-1:0] OMIN = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic w_accept;
  assign w_accept = i_ce & i_valid;

  // -------------------------------------------------------------------------
  // NCO: accumulator and increment register
  // -------------------------------------------------------------------------
  logic [AW-1:0] r_acc;
  logic [AW-1:0] r_inc;

  // Increment load ignores i_ce so software can retune during a stall.
  always_ff @(posedge i_clk) begin
    if (i_reset)       r_inc <= '0;
    else if (i_update) r_inc <= i_increment;
  end

  // The accepted sample sees the pre-update acc; wrap is plain modulo 2^AW.
  always_ff @(posedge i_clk) begin
    if (i_reset)       r_acc <= '0;
    else if (w_accept) r_acc <= r_acc + r_inc;
  end

  logic [AW-1:0] w_dith;

`ifdef IQ_MIXER_DITHER_EN
  localparam int DW = ((AW - PW) < 15) ? (AW - PW) : 15;
  logic [14:0] r_lfsr;

  // x^15 + x^14 + 1 Fibonacci form; the sample uses the pre-advance state.
  always_ff @(posedge i_clk) begin
    if (i_reset)       r_lfsr <= 15'd1;
    else if (w_accept) r_lfsr <= {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
  end

  assign w_dith = {{(AW-DW){1'b0}}, r_lfsr[DW-1:0]};
`else
  assign w_dith = '0;
`endif

  logic [AW-1:0] w_phase;
  logic [PW-1:0] w_idx;

  assign w_phase = r_acc + {i_phase_offset, {(AW-PW){1'b0}}} + w_dith;
  assign w_idx   = PW'(w_phase >> (AW - PW));

  // -------------------------------------------------------------------------
  // Quarter-wave sine ROM, 0..N4 inclusive so both quadrant ends are exact.
  // Values are elaboration-time constants: round(A*sin(2*pi*m/2^PW)).
  // -------------------------------------------------------------------------
  logic signed [LW-1:0] w_qrom [0:N4];

  for (genvar m = 0; m <= N4; m++) begin : g_qrom
    localparam real AMP = (2.0 ** (LW - 1)) - 1.0;
    localparam real ANG = 6.283185307179586 * m / (4.0 * N4);
    localparam int  VAL = $rtoi(AMP * $sin(ANG) + 0.5);
    assign w_qrom[m] = LW'(VAL);
  end

  logic [1:0]           w_quad;
  logic [PW-2:0]        w_r;
  logic [PW-2:0]        w_rc;
  logic signed [LW-1:0] w_qs;
  logic signed [LW-1:0] w_qc;
  logic signed [LW-1:0] w_cos;
  logic signed [LW-1:0] w_sin;

  assign w_quad = w_idx[PW-1:PW-2];
  assign w_r    = {1'b0, w_idx[PW-3:0]};
  assign w_rc   = (PW-1)'(N4) - w_r;   // mirrored position inside the quadrant
  assign w_qs   = w_qrom[w_r];
  assign w_qc   = w_qrom[w_rc];

  // Fold the full turn onto the quarter table by quadrant symmetry.
  always_comb begin
    w_sin = w_qs;
    w_cos = w_qc;
    unique case (w_quad)
      2'd0: begin w_sin =  w_qs; w_cos =  w_qc; end
      2'd1: begin w_sin =  w_qc; w_cos = -w_qs; end
      2'd2: begin w_sin = -w_qs; w_cos = -w_qc; end
      2'd3: begin w_sin = -w_qc; w_cos =  w_qs; end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Pipeline. Valid bits shift on every enabled edge; data registers load
  // only behind a valid so outputs hold their last value through bubbles.
  // -------------------------------------------------------------------------
  logic [3:1]            r_vld_pipe;

  logic signed [IW-1:0]  r_xi, r_xq;
  logic signed [LW-1:0]  r_cos, r_sin;
  logic                  r_m1;

  logic signed [PRW-1:0] r_a, r_b, r_c, r_d;
  logic                  r_m2;

  logic signed [OW-1:0]  r_oi, r_oq;

  // S3 combine / round / saturate
  logic signed [SW-1:0]  w_a, w_b, w_c, w_d;
  logic signed [SW-1:0]  w_sum_i, w_sum_q;
  logic signed [SW-1:0]  w_rnd_i, w_rnd_q;

  assign w_a = SW'(r_a);
  assign w_b = SW'(r_b);
  assign w_c = SW'(r_c);
  assign w_d = SW'(r_d);

  always_comb begin
    w_sum_i = w_a;
    w_sum_q = -w_b;
    if (r_m2) begin
      w_sum_i = w_a + w_d;
      w_sum_q = w_c - w_b;
    end
  end

  // Half-up: add half an LSB of the kept result, then floor via >>>.
  assign w_rnd_i = (w_sum_i + RND) >>> (LW - 1);
  assign w_rnd_q = (w_sum_q + RND) >>> (LW - 1);

  function automatic logic signed [OW-1:0] sat(input logic signed [SW-1:0] v);
    if (v > OMAX)      sat = OMAX[OW-1:0];
    else if (v < OMIN) sat = OMIN[OW-1:0];
    else               sat = v[OW-1:0];
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vld_pipe <= '0;
      r_xi  <= '0;  r_xq  <= '0;
      r_cos <= '0;  r_sin <= '0;
      r_m1  <= 1'b0;
      r_a   <= '0;  r_b   <= '0;
      r_c   <= '0;  r_d   <= '0;
      r_m2  <= 1'b0;
      r_oi  <= '0;  r_oq  <= '0;
    end else if (i_ce) begin
      r_vld_pipe <= {r_vld_pipe[2:1], i_valid};
      // S1: table lookup, data and mode travel together
      if (i_valid) begin
        r_cos <= w_cos;
        r_sin <= w_sin;
        r_xi  <= i_data_i;
        r_xq  <= i_data_q;
        r_m1  <= i_mode;
      end
      // S2: full-width products
      if (r_vld_pipe[1]) begin
        r_a  <= PRW'(r_xi) * PRW'(r_cos);
        r_b  <= PRW'(r_xi) * PRW'(r_sin);
        r_c  <= PRW'(r_xq) * PRW'(r_cos);
        r_d  <= PRW'(r_xq) * PRW'(r_sin);
        r_m2 <= r_m1;
      end
      // S3: rounded, saturated outputs
      if (r_vld_pipe[2]) begin
        r_oi <= sat(w_rnd_i);
        r_oq <= sat(w_rnd_q);
      end
    end
  end

  assign o_valid    = r_vld_pipe[3];
  assign o_signal_i = r_oi;
  assign o_signal_q = r_oq;

endmodule

// File: tb/tb_iq_mixer.sv
// Scoreboard bench for iq_mixer. A driver applies directed and random
// stimulus on the falling edge and pushes the expected result of every
// accepted sample, computed from the mixing equations with plain integer
// and real arithmetic. A monitor samples 1 time unit after each rising edge,
// pops and compares valid outputs, checks latency in enabled edges, and
// checks the hold behaviour during stalls, bubbles and reset.
module tb_iq_mixer;
  localparam int IW = 16, OW = 16, LW = 16, PW = 12, AW = 32;

  logic                 clk = 1'b0;
  logic                 i_reset, i_ce, i_valid, i_mode, i_update;
  logic signed [IW-1:0] i_data_i, i_data_q;
  logic        [AW-1:0] i_increment;
  logic        [PW-1:0] i_phase_offset;
  logic                 o_valid;
  logic signed [OW-1:0] o_signal_i, o_signal_q;

  always #5 clk = ~clk;

  iq_mixer #(.IW(IW), .OW(OW), .LW(LW), .PW(PW), .AW(AW)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_valid(i_valid),
    .i_mode(i_mode), .i_data_i(i_data_i), .i_data_q(i_data_q),
    .i_update(i_update), .i_increment(i_increment),
    .i_phase_offset(i_phase_offset), .o_valid(o_valid),
    .o_signal_i(o_signal_i), .o_signal_q(o_signal_q));

  typedef struct { int ei; int eq; int tag; } exp_t;
  exp_t sb[$];

  int n_vec = 0, n_err = 0;
  int en_cnt = 0;            // enabled, non-reset rising edges so far
  bit [AW-1:0] m_acc = '0, m_inc = '0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int rnd_away(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  function automatic int tab(input int k, input bit is_sin);
    real amp, ang;
    amp = (2.0 ** (LW - 1)) - 1.0;
    ang = 2.0 * 3.141592653589793 * k / (2.0 ** PW);
    return is_sin ? rnd_away(amp * $sin(ang)) : rnd_away(amp * $cos(ang));
  endfunction

  function automatic int sat(input longint v);
    longint hi, lo;
    hi = (longint'(1) <<< (OW - 1)) - 1;
    lo = -(longint'(1) <<< (OW - 1));
    return int'((v > hi) ? hi : (v < lo) ? lo : v);
  endfunction

  // (x*cos - j x*sin) for real input; (xi + j xq)(cos - j sin) for complex.
  // Rounding is floor(v / 2^(LW-1) + 1/2).
  function automatic exp_t model(input int xi, input int xq, input bit mode,
                                 input bit [PW-1:0] off);
    exp_t e;
    bit [AW-1:0] ph;
    int k;
    longint c, s, a, b, cq, d, si, sq;
    ph = m_acc + (AW'(off) << (AW - PW));
    k  = int'(ph >> (AW - PW));
    c  = tab(k, 1'b0);
    s  = tab(k, 1'b1);
    a  = xi * c;  b = xi * s;  cq = xq * c;  d = xq * s;
    si = mode ? a + d : a;
    sq = mode ? cq - b : -b;
    e.ei  = sat((si + (longint'(1) <<< (LW - 2))) >>> (LW - 1));
    e.eq  = sat((sq + (longint'(1) <<< (LW - 2))) >>> (LW - 1));
    e.tag = 0;
    return e;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input bit rst, input bit ce, input bit vld, input bit mode,
                       input bit upd, input int xi, input int xq,
                       input bit [AW-1:0] inc, input bit [PW-1:0] off);
    exp_t e;
    @(negedge clk);
    i_reset = rst; i_ce = ce; i_valid = vld; i_mode = mode; i_update = upd;
    i_data_i = IW'(xi); i_data_q = IW'(xq);
    i_increment = inc; i_phase_offset = off;
    if (rst) begin
      sb.delete();
      m_acc = '0;
      m_inc = '0;
    end else begin
      if (ce && vld) begin
        e = model(xi, xq, mode, off);
        e.tag = en_cnt + 3;     // accepted on edge en_cnt+1, out two edges later
        sb.push_back(e);
        m_acc = m_acc + m_inc;
      end
      if (upd) m_inc = inc;
    end
  endtask

  // ---------------- monitor ----------------
  logic signed [OW-1:0] last_i = '0, last_q = '0;
  logic                 last_v = 1'b0;
  bit                   mon_ce, mon_rst;

  always @(posedge clk) begin
    exp_t e;
    mon_ce  = i_ce;
    mon_rst = i_reset;
    if (!mon_rst && mon_ce) en_cnt++;
    #1;
    if (mon_rst) begin
      chk("reset_valid", o_valid, 0);
      chk("reset_i", o_signal_i, 0);
      chk("reset_q", o_signal_q, 0);
    end else if (!mon_ce) begin
      chk("stall_valid", o_valid, last_v);
      chk("stall_i", o_signal_i, last_i);
      chk("stall_q", o_signal_q, last_q);
    end else if (!o_valid) begin
      chk("bubble_i", o_signal_i, last_i);
      chk("bubble_q", o_signal_q, last_q);
    end else if (sb.size() == 0) begin
      chk("unexpected_valid", o_valid, 0);
    end else begin
      e = sb.pop_front();
      chk("latency", en_cnt, e.tag);
      chk("sig_i", o_signal_i, e.ei);
      chk("sig_q", o_signal_q, e.eq);
    end
    last_v = o_valid;
    last_i = o_signal_i;
    last_q = o_signal_q;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int xi, xq;
    bit ce, vld, upd, mode;
    i_reset = 1'b1; i_ce = 1'b0; i_valid = 1'b0; i_mode = 1'b0; i_update = 1'b0;
    i_data_i = '0; i_data_q = '0; i_increment = '0; i_phase_offset = '0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);

    // DC carrier at phase 0 and at quarter-turn offset
    repeat (6) drive(0, 1, 1, 0, 0, 16384, 0, 0, 12'h000);
    repeat (6) drive(0, 1, 1, 0, 0, 16384, 0, 0, 12'h400);

    // fs/4 rotation, accumulator wraps every four samples
    drive(0, 1, 1, 0, 1, 16384, 0, 32'h4000_0000, 12'h000);
    repeat (12) drive(0, 1, 1, 0, 0, 16384, 0, 0, 12'h000);

    // complex input at 45 degrees: saturation then exact sqrt(2) gain
    drive(0, 1, 0, 0, 1, 0, 0, 32'h0, 12'h000);
    repeat (4) drive(0, 1, 1, 1, 0, -32768, -32768, 0, 12'h200);
    repeat (4) drive(0, 1, 1, 1, 0, 1000, 1000, 0, 12'h200);

    // stall mid-stream with alternating valid and a retune during the stall
    drive(0, 1, 0, 0, 1, 0, 0, 32'h1234_5678, 12'h000);
    for (int i = 0; i < 6; i++) drive(0, 1, i[0], i[1], 0, 3000 + i * 111, -2000, 0, 12'h010);
    for (int i = 0; i < 5; i++) drive(0, 0, i[0], 1, (i == 2), 7777, 7777, 32'h0800_0000, 12'h010);
    for (int i = 0; i < 8; i++) drive(0, 1, i[0], 1, 0, -5000 + i * 97, 4321, 0, 12'h020);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      ce   = ($urandom_range(0, 7) != 0);
      vld  = ($urandom_range(0, 3) != 0);
      mode = 1'($urandom);
      upd  = ($urandom_range(0, 15) == 0);
      xi   = int'($urandom_range(0, 65535)) - 32768;
      xq   = int'($urandom_range(0, 65535)) - 32768;
      if ($urandom_range(0, 7) == 0) xi = -32768;
      if ($urandom_range(0, 7) == 0) xq = -32768;
      drive(0, ce, vld, mode, upd, xi, xq, $urandom, PW'($urandom));
    end

    // reset with three samples in flight; afterwards acc and inc are zero
    drive(0, 1, 0, 0, 1, 0, 0, 32'h2000_0000, 12'h000);
    repeat (3) drive(0, 1, 1, 1, 0, 12345, -23456, 0, 12'h0AB);
    drive(1, 1, 1, 0, 0, 0, 0, 0, 12'h000);
    repeat (4) drive(0, 1, 0, 0, 0, 0, 0, 0, 12'h000);
    repeat (3) drive(0, 1, 1, 0, 0, -16384, 0, 0, 12'h000);

    // drain
    repeat (6) drive(0, 1, 0, 0, 0, 0, 0, 0, 12'h000);
    @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
